// File: rtl/divider_8x8_seq.sv
// -----------------------------------------------------------------------------
// divider_8x8_seq
//
// Iterative radix-2 restoring divider. It is the inverse datapath of the 8x8
// multiplier in the NPU MAC unit and uses the same Sign convention
// (0 = unsigned, 1 = two's complement). The divider produces one quotient bit
// per cycle and has only one operation in flight at a time. Results are
// returned over a valid/ready handshake.
//
// Ports
//   Clk          in   1      rising-edge clock
//   Rst_n        in   1      asynchronous active-low reset
//   In_Valid     in   1      Dividend/Divisor/Sign are valid
//   In_Ready     out  1      operands can be accepted (IDLE only)
//   Dividend     in   WIDTH  numerator
//   Divisor      in   WIDTH  denominator
//   Sign         in   1      1 = signed two's complement, 0 = unsigned
//   Out_Valid    out  1      Quotient/Remainder/Div_By_Zero are valid
//   Out_Ready    in   1      consumer accepts the result
//   Quotient     out  WIDTH  quotient, truncated toward zero
//   Remainder    out  WIDTH  remainder, sign follows the dividend
//   Div_By_Zero  out  1      set together with the result when Divisor == 0
//
// Flow: IDLE -> CALC (WIDTH cycles) -> FIX -> DONE -> IDLE.
//       A zero divisor goes straight from IDLE to DONE.
// -----------------------------------------------------------------------------
module divider_8x8_seq #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    input  logic             Sign,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Div_By_Zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's complement negation modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1'b1);
    endfunction

    // Magnitude of an operand. A signed most-negative value maps onto itself,
    // and that value is then read as an unsigned number, 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v,
                                               input logic              is_signed);
        return (is_signed && v[WIDTH-1]) ? f_neg(v) : v;
    endfunction

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;

    logic               r_neg_q;     // final quotient must be negated
    logic               r_neg_r;     // final remainder must be negated
    logic [WIDTH-1:0]   r_dvsr;      // divisor magnitude
    logic [WIDTH-1:0]   r_rem;       // partial remainder (magnitude)
    logic [WIDTH-1:0]   r_quo;       // dividend magnitude shifting out, quotient shifting in
    logic [CW-1:0]      r_cnt;       // CALC iteration counter

    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_trial;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic               w_unused_trial_bit;

    // One restoring step: shift {rem,quo} left and try to subtract the divisor.
    always_comb begin
        w_shift            = {r_rem, r_quo[WIDTH-1]};
        // An extra guard bit above the shifted value makes the sign of the
        // trial difference directly visible in the MSB.
        w_trial            = {1'b0, w_shift} - {2'b00, r_dvsr};
        w_fits             = ~w_trial[WIDTH+1];
        // When the subtraction fits, the difference is below the divisor,
        // so bit WIDTH of the trial is always zero and is not needed.
        w_unused_trial_bit = w_trial[WIDTH];
        if (w_fits) begin
            w_rem_next = w_trial[WIDTH-1:0];
        end else begin
            w_rem_next = w_shift[WIDTH-1:0];
        end
        w_quo_next = {r_quo[WIDTH-2:0], w_fits};
    end

    // Control FSM plus datapath registers and the registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state       <= S_IDLE;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_quotient    <= {WIDTH{1'b0}};
            r_remainder   <= {WIDTH{1'b0}};
            r_div_by_zero <= 1'b0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dvsr        <= {WIDTH{1'b0}};
            r_rem         <= {WIDTH{1'b0}};
            r_quo         <= {WIDTH{1'b0}};
            r_cnt         <= {CW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (In_Valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_neg_q    <= Sign & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
                        r_neg_r    <= Sign & Dividend[WIDTH-1];
                        r_dvsr     <= f_mag(Divisor, Sign);
                        r_quo      <= f_mag(Dividend, Sign);
                        r_rem      <= {WIDTH{1'b0}};
                        r_cnt      <= {CW{1'b0}};
                        if (Divisor == {WIDTH{1'b0}}) begin
                            // Divide by zero: the result is ready immediately.
                            // The raw dividend bits pass through unchanged.
                            r_quotient    <= {WIDTH{1'b1}};
                            r_remainder   <= Dividend;
                            r_div_by_zero <= 1'b1;
                            r_out_valid   <= 1'b1;
                            r_state       <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end

                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_FIX: begin
                    // Signed overflow (most negative / -1) falls out naturally:
                    // the magnitude quotient 2^(WIDTH-1) stays un-negated.
                    r_quotient    <= r_neg_q ? f_neg(r_quo) : r_quo;
                    r_remainder   <= r_neg_r ? f_neg(r_rem) : r_rem;
                    r_div_by_zero <= 1'b0;
                    r_out_valid   <= 1'b1;
                    r_state       <= S_DONE;
                end

                S_DONE: begin
                    if (Out_Ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign In_Ready    = r_in_ready;
    assign Out_Valid   = r_out_valid;
    assign Quotient    = r_quotient;
    assign Remainder   = r_remainder;
    assign Div_By_Zero = r_div_by_zero;

endmodule

// File: tb/tb_divider_8x8_seq.sv
// -----------------------------------------------------------------------------
// Self-checking bench for divider_8x8_seq (WIDTH = 8).
// Expected results come from an integer-arithmetic model of the divide rules.
// A queue of those results feeds one compare process. Each directed vector
// also carries hand-computed values that pin both the DUT and the model.
// -----------------------------------------------------------------------------
module tb_divider_8x8_seq;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       In_Valid = 1'b0;
    logic       In_Ready;
    logic [7:0] Dividend = 8'h00;
    logic [7:0] Divisor = 8'h00;
    logic       Sign = 1'b0;
    logic       Out_Valid;
    logic       Out_Ready = 1'b0;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Div_By_Zero;

    int checks = 0;
    int failures = 0;

    logic [16:0] exp_q[$];   // {div_by_zero, quotient, remainder}

    divider_8x8_seq #(.WIDTH(8)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .Sign        (Sign),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Div_By_Zero (Div_By_Zero)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: plain integer division. SV int division truncates toward zero, and
    // the remainder takes the sign of the dividend. -128/-1 = +128 wraps to 0x80.
    function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        int ia;
        int ib;
        int iq;
        int ir;
        if (b == 8'h00) return {1'b1, 8'hFF, a};
        if (s) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'(a);
            ib = int'(b);
        end
        iq = ia / ib;
        ir = ia % ib;
        return {1'b0, iq[7:0], ir[7:0]};
    endfunction

    // Compare process: every cycle a result is presented, it must match the model.
    always @(negedge Clk) begin
        if (Rst_n && Out_Valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                check("cmp_quotient", {24'd0, Quotient}, {24'd0, exp_q[0][15:8]});
                check("cmp_remainder", {24'd0, Remainder}, {24'd0, exp_q[0][7:0]});
                check("cmp_div_by_zero", {31'd0, Div_By_Zero}, {31'd0, exp_q[0][16]});
                check("cmp_in_ready_busy", {31'd0, In_Ready}, 32'd0);
                if (Out_Ready) void'(exp_q.pop_front());
            end
        end
    end

    // Issue one operation and check it against the given expected values.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez,
                         input int hold, input bit pulse_in);
        int waited;
        int lat;
        Dividend = a;
        Divisor  = b;
        Sign     = s;
        In_Valid = 1'b1;
        waited = 0;
        while (!In_Ready && waited < 40) begin
            @(posedge Clk); #1;
            waited++;
        end
        if (!In_Ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            In_Valid = 1'b0;
            return;
        end
        @(posedge Clk);
        exp_q.push_back(model(a, b, s));
        #1;
        In_Valid = 1'b0;
        Dividend = ~a;           // operands changing after accept must not matter
        Divisor  = ~b;
        Sign     = ~s;
        lat = 1;
        while (!Out_Valid && lat < 40) begin
            @(posedge Clk); #1;
            lat++;
        end
        check("latency", lat, ez ? 32'd1 : 32'd10);
        check("quotient", {24'd0, Quotient}, {24'd0, eq});
        check("remainder", {24'd0, Remainder}, {24'd0, er});
        check("div_by_zero", {31'd0, Div_By_Zero}, {31'd0, ez});
        for (int h = 0; h < hold; h++) begin
            if (pulse_in) begin
                In_Valid = 1'b1;
                Dividend = 8'h11;
                Divisor  = 8'h01;
            end
            @(posedge Clk); #1;
            check("hold_in_ready", {31'd0, In_Ready}, 32'd0);
            check("hold_out_valid", {31'd0, Out_Valid}, 32'd1);
        end
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        @(posedge Clk); #1;
        Out_Ready = 1'b0;
        check("consumed_out_valid", {31'd0, Out_Valid}, 32'd0);
        check("consumed_in_ready", {31'd0, In_Ready}, 32'd1);
    endtask

    // Directed vector: pin the model to the hand value, then run the DUT.
    task automatic vec(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [7:0] eq, input logic [7:0] er, input logic ez);
        logic [16:0] m;
        m = model(a, b, s);
        check("model_pin", {15'd0, m}, {15'd0, ez, eq, er});
        do_op(a, b, s, eq, er, ez, 0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rs;
        logic [16:0] m;

        // Reset state
        #12;
        check("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
        check("rst_quotient", {24'd0, Quotient}, 32'd0);
        check("rst_remainder", {24'd0, Remainder}, 32'd0);
        check("rst_dbz", {31'd0, Div_By_Zero}, 32'd0);
        check("rst_in_ready", {31'd0, In_Ready}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        check("in_ready_after_release", {31'd0, In_Ready}, 32'd1);

        // Directed vectors with hand-computed results
        vec(8'd200, 8'd7,  1'b0, 8'd28,  8'd4,  1'b0);
        vec(8'hF9,  8'h02, 1'b1, 8'hFD,  8'hFF, 1'b0);
        vec(8'h07,  8'hFE, 1'b1, 8'hFD,  8'h01, 1'b0);
        vec(8'h80,  8'hFF, 1'b1, 8'h80,  8'h00, 1'b0);
        vec(8'h80,  8'hFF, 1'b0, 8'h00,  8'h80, 1'b0);
        vec(8'h55,  8'h00, 1'b0, 8'hFF,  8'h55, 1'b1);
        vec(8'h85,  8'h00, 1'b1, 8'hFF,  8'h85, 1'b1);
        vec(8'h05,  8'h09, 1'b0, 8'h00,  8'h05, 1'b0);
        vec(8'hFB,  8'h09, 1'b1, 8'h00,  8'hFB, 1'b0);
        vec(8'hFF,  8'h01, 1'b0, 8'hFF,  8'h00, 1'b0);
        vec(8'h80,  8'h80, 1'b1, 8'h01,  8'h00, 1'b0);
        vec(8'h80,  8'h02, 1'b1, 8'hC0,  8'h00, 1'b0);
        vec(8'hFF,  8'hFF, 1'b0, 8'h01,  8'h00, 1'b0);

        // Backpressure: 100/7 held 5 cycles in DONE with In_Valid pulses
        do_op(8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 5, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(posedge Clk); #1;
        end
        check("dropped_pulses_no_result", {31'd0, Out_Valid}, 32'd0);

        // Reset in the 4th CALC cycle. The previous result (28) is still on the outputs.
        do_op(8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 0, 1'b0);
        Dividend = 8'hF0;
        Divisor  = 8'h03;
        Sign     = 1'b0;
        In_Valid = 1'b1;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_out_valid", {31'd0, Out_Valid}, 32'd0);
        check("abort_quotient", {24'd0, Quotient}, 32'd0);
        check("abort_remainder", {24'd0, Remainder}, 32'd0);
        check("abort_in_ready", {31'd0, In_Ready}, 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        check("in_ready_after_abort", {31'd0, In_Ready}, 32'd1);
        vec(8'd100, 8'd10, 1'b0, 8'd10, 8'd0, 1'b0);

        // Random operations against the model, including zero divisors
        for (int n = 0; n < 400; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            m  = model(ra, rb, rs);
            do_op(ra, rb, rs, m[15:8], m[7:0], m[16], $urandom_range(0, 2), 1'b0);
        end

        repeat (3) @(posedge Clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
